// File: rtl/led_status_seq.sv
// ---------------------------------------------------------------------------
// led_status_seq
//
// Status LED sequencer. While idle the status LED mirrors the ~1 Hz
// configuration heartbeat. A status code (1..15) is flashed out as a burst of
// countable blinks: k on-phases of N_FLASH cycles, each followed by an
// off-phase of N_FLASH cycles, then a dark gap of N_GAP cycles before the
// heartbeat resumes. A separate activity LED shows a pulse-stretched copy of
// single-cycle pulse events (minimum on-time N_STR cycles, retriggerable).
//
// Optional feature macro: LED_STATUS_REPEAT_EN
//   defined   : latched code is sticky and the burst repeats after each gap;
//               code_valid is accepted in any state (code 0 stops repetition
//               after the current burst, nonzero replaces the next burst).
//   undefined : one-shot burst; code_valid is ignored while busy.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   heartbeat    in   ~1 Hz square wave
//   code[3:0]    in   status code = number of flashes (0 is ignored)
//   code_valid   in   single-cycle strobe qualifying code
//   pulse_event  in   single-cycle strobe, one per generated pulse
//   led_status   out  status LED drive (registered)
//   led_act      out  activity LED drive (registered)
//   busy         out  high whenever the sequencer is not idle (registered)
// ---------------------------------------------------------------------------
module led_status_seq #(
    parameter longint P_CLK_FREQ_HZ = 100000000,
    parameter longint P_FLASH_MS    = 150,
    parameter longint P_GAP_MS      = 1000,
    parameter longint P_STRETCH_MS  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       heartbeat,
    input  logic [3:0] code,
    input  logic       code_valid,
    input  logic       pulse_event,
    output logic       led_status,
    output logic       led_act,
    output logic       busy
);

    localparam longint N_FLASH = P_CLK_FREQ_HZ / 64'sd1000 * P_FLASH_MS;
    localparam longint N_GAP   = P_CLK_FREQ_HZ / 64'sd1000 * P_GAP_MS;
    localparam longint N_STR   = P_CLK_FREQ_HZ / 64'sd1000 * P_STRETCH_MS;

    localparam longint N_MAX_FG = (N_FLASH > N_GAP) ? N_FLASH : N_GAP;
    localparam longint N_MAX    = (N_MAX_FG > N_STR) ? N_MAX_FG : N_STR;

    // Counters are loaded with (count - 1), so ceil(log2(max)) bits suffice.
    localparam int CNT_W_RAW = $clog2(N_MAX);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

    localparam logic [CNT_W-1:0] LD_FLASH = CNT_W'(N_FLASH - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(N_GAP - 1);
    localparam logic [CNT_W-1:0] LD_STR   = CNT_W'(N_STR - 1);

    if (N_FLASH < 1) begin : g_bad_flash
        $error("led_status_seq: flash cycle count must be at least 1");
    end
    if (N_GAP < 1) begin : g_bad_gap
        $error("led_status_seq: gap cycle count must be at least 1");
    end
    if (N_STR < 1) begin : g_bad_str
        $error("led_status_seq: stretch cycle count must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       remaining, remaining_next;
    logic [CNT_W-1:0] act_cnt, act_cnt_next;
    logic             led_status_next, led_act_next, busy_next;
`ifdef LED_STATUS_REPEAT_EN
    logic [3:0]       latched, latched_next;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            remaining  <= '0;
            act_cnt    <= '0;
            led_status <= 1'b0;
            led_act    <= 1'b0;
            busy       <= 1'b0;
`ifdef LED_STATUS_REPEAT_EN
            latched    <= '0;
`endif
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            remaining  <= remaining_next;
            act_cnt    <= act_cnt_next;
            led_status <= led_status_next;
            led_act    <= led_act_next;
            busy       <= busy_next;
`ifdef LED_STATUS_REPEAT_EN
            latched    <= latched_next;
`endif
        end
    end

    // Next-state logic. Each phase counter holds the cycles left after the
    // current one, so a phase ends on the cycle where it reads zero.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        remaining_next = remaining;
`ifdef LED_STATUS_REPEAT_EN
        latched_next   = latched;
        if (code_valid) begin
            latched_next = code;
        end
`endif
        case (state)
            S_IDLE: begin
                if (code_valid && (code != 4'd0)) begin
                    state_next     = S_ON;
                    cnt_next       = LD_FLASH;
                    remaining_next = code;
                end
            end
            S_ON: begin
                if (cnt == '0) begin
                    state_next = S_OFF;
                    cnt_next   = LD_FLASH;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_OFF: begin
                if (cnt == '0) begin
                    remaining_next = remaining - 4'd1;
                    if (remaining == 4'd1) begin
                        state_next = S_GAP;
                        cnt_next   = LD_GAP;
                    end else begin
                        state_next = S_ON;
                        cnt_next   = LD_FLASH;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
`ifdef LED_STATUS_REPEAT_EN
                    if (latched != 4'd0) begin
                        state_next     = S_ON;
                        cnt_next       = LD_FLASH;
                        remaining_next = latched;
                    end else begin
                        state_next = S_IDLE;
                    end
`else
                    state_next = S_IDLE;
`endif
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic, evaluated on the next state so the registered outputs
    // line up with the state they describe.
    always_comb begin
        led_status_next = 1'b0;
        busy_next       = (state_next != S_IDLE);
        case (state_next)
            S_IDLE:  led_status_next = heartbeat;
            S_ON:    led_status_next = 1'b1;
            default: led_status_next = 1'b0;
        endcase
    end

    // Activity stretcher: an event reloads the counter (retrigger). The LED
    // is lit for the event cycle's successor plus the remaining count.
    always_comb begin
        act_cnt_next = act_cnt;
        if (pulse_event) begin
            act_cnt_next = LD_STR;
        end else if (act_cnt != '0) begin
            act_cnt_next = act_cnt - 1'b1;
        end
        led_act_next = pulse_event || (act_cnt != '0);
    end

endmodule

// File: tb/tb_led_status_seq.sv
module tb_led_status_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       heartbeat = 1'b0;
    logic [3:0] code = 4'd0;
    logic       code_valid = 1'b0;
    logic       pulse_event = 1'b0;
    logic       led_status, led_act, busy;

    int checks = 0;
    int failures = 0;

    localparam int NF = 20;
    localparam int NG = 50;

    led_status_seq #(
        .P_CLK_FREQ_HZ(10000),
        .P_FLASH_MS(2),
        .P_GAP_MS(5),
        .P_STRETCH_MS(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .heartbeat(heartbeat),
        .code(code),
        .code_valid(code_valid),
        .pulse_event(pulse_event),
        .led_status(led_status),
        .led_act(led_act),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, c, obs, exp);
        end
    endtask

    // Starts a burst of code k at cycle 0 and checks every cycle through
    // two cycles past the end. An optional extra strobe is injected at
    // cycle inj (0 = none).
    task automatic burst(input int k, input int inj, input logic [3:0] inj_code);
        int total;
        logic exp_led;
        total = 2 * k * NF + NG;
        heartbeat  = 1'b1;
        code       = 4'(k);
        code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        for (int c = 1; c <= total + 2; c++) begin
            if (c <= 2 * k * NF) exp_led = (((c - 1) % (2 * NF)) < NF);
            else if (c <= total) exp_led = 1'b0;
            else exp_led = heartbeat;
            chk("burst_led", c, led_status, exp_led);
            chk("burst_busy", c, busy, (c <= total));
            if (c == inj) begin
                code = inj_code;
                code_valid = 1'b1;
            end
            step();
            code_valid = 1'b0;
        end
    endtask

    initial begin
        logic prev;

        // Reset state, with inputs active to prove they are masked
        rst = 1'b1;
        heartbeat = 1'b1;
        pulse_event = 1'b1;
        step();
        pulse_event = 1'b0;
        step();
        chk("rst_led", 0, led_status, 1'b0);
        chk("rst_act", 0, led_act, 1'b0);
        chk("rst_busy", 0, busy, 1'b0);

        // Heartbeat passthrough with one cycle latency
        rst = 1'b0;
        heartbeat = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            prev = led_status;
            heartbeat = ~heartbeat;
            chk("hb_hold", i, led_status, prev);
            step();
            chk("hb_follow", i, led_status, heartbeat);
            chk("hb_busy", i, busy, 1'b0);
            chk("hb_act", i, led_act, 1'b0);
        end

        // Zero code in idle is ignored
        code = 4'd0;
        code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        chk("zero_code_busy", 1, busy, 1'b0);
        step();

`ifndef LED_STATUS_REPEAT_EN
        // One-shot bursts, including an ignored strobe while busy
        burst(3, 0, 4'd0);
        burst(3, 30, 4'd5);
        burst(1, 0, 4'd0);
`endif

        // Activity stretch with retrigger at cycle 6
        pulse_event = 1'b1;
        step();
        pulse_event = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            chk("act", c, led_act, (c <= 16));
            if (c == 6) pulse_event = 1'b1;
            step();
            pulse_event = 1'b0;
        end

        // Same-cycle code_valid and pulse_event
        heartbeat = 1'b0;
        code = 4'd1;
        code_valid = 1'b1;
        pulse_event = 1'b1;
        step();
        code_valid = 1'b0;
        pulse_event = 1'b0;
        chk("both_led", 1, led_status, 1'b1);
        chk("both_busy", 1, busy, 1'b1);
        chk("both_act", 1, led_act, 1'b1);
`ifdef LED_STATUS_REPEAT_EN
        code = 4'd0;
        code_valid = 1'b1;
        step();
        code_valid = 1'b0;
`endif
        for (int i = 0; i < 300 && busy; i++) step();
        chk("both_drain", 0, busy, 1'b0);

        // Reset mid-burst (code 4) at cycle 50, activity LED lit at the time
        heartbeat = 1'b1;
        code = 4'd4;
        code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        for (int c = 1; c < 50; c++) begin
            if (c == 45) pulse_event = 1'b1;
            step();
            pulse_event = 1'b0;
        end
        chk("pre_rst_busy", 50, busy, 1'b1);
        chk("pre_rst_act", 50, led_act, 1'b1);
        rst = 1'b1;
        step();
        chk("mid_rst_led", 51, led_status, 1'b0);
        chk("mid_rst_act", 51, led_act, 1'b0);
        chk("mid_rst_busy", 51, busy, 1'b0);
        rst = 1'b0;
        step();
        chk("post_rst_led", 52, led_status, 1'b1);
        chk("post_rst_busy", 52, busy, 1'b0);
        step();
        chk("post_rst_idle", 53, busy, 1'b0);

`ifdef LED_STATUS_REPEAT_EN
        // Code 2 repeats every 130 cycles; code 0 during the second burst
        // lets that burst finish, then idle.
        heartbeat = 1'b1;
        code = 4'd2;
        code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        for (int c = 1; c <= 265; c++) begin
            int ph;
            logic exp_led;
            ph = (c - 1) % 130;
            if (c <= 260) exp_led = (ph < 4 * NF) && ((ph % (2 * NF)) < NF);
            else exp_led = heartbeat;
            chk("rep_led", c, led_status, exp_led);
            chk("rep_busy", c, busy, (c <= 260));
            if (c == 150) begin
                code = 4'd0;
                code_valid = 1'b1;
            end
            step();
            code_valid = 1'b0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_status_seq.md
# led_status_seq

Status LED sequencer driven directly by the configuration-indicator heartbeat. It drives the board's status LED. While idle, that LED shows the ~1 Hz heartbeat. When the pulse generator reports a status code, the block flashes the code out as a countable burst of blinks. A second output is an activity LED: a pulse-stretched copy of single-cycle pulse-generator events, so each event is visible to the eye.

## Interface
- P_CLK_FREQ_HZ, 100000000, system clock frequency in Hz.
- P_FLASH_MS, 150, length of each flash on-phase and of each off-phase, in ms.
- P_GAP_MS, 1000, dark gap after a burst before the heartbeat resumes, in ms.
- P_STRETCH_MS, 50, minimum on-time of the activity LED per event, in ms.
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- heartbeat  input  1  ~1 Hz square wave from the configuration indicator.
- code  input  4  status code; value = number of flashes (1..15).
- code_valid  input  1  single-cycle strobe qualifying `code`.
- pulse_event  input  1  single-cycle strobe, one per generated pulse.
- led_status  output  1  status LED drive.
- led_act  output  1  activity LED drive.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- Derived cycle counts: N_FLASH = P_CLK_FREQ_HZ/1000*P_FLASH_MS, N_GAP = P_CLK_FREQ_HZ/1000*P_GAP_MS, N_STR = P_CLK_FREQ_HZ/1000*P_STRETCH_MS.
  - Each count is computed in 64-bit integer math at elaboration.
  - Each count must be at least 1.
  - A single phase counter is sized with ceil(log2) of the largest count.
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - led_status = heartbeat.
  - code_valid with code != 0 latches code into `remaining` and the phase counter is loaded. Next state is ON.
  - code_valid with code == 0 is ignored.
- ON: led_status = 1 for N_FLASH cycles, then go to OFF.
- OFF: led_status = 0 for N_FLASH cycles. At the end, decrement `remaining`:
  - if `remaining` becomes 0, go to GAP;
  - otherwise go to ON.
- GAP: led_status = 0 for N_GAP cycles, then go to IDLE (see Configuration).
- code_valid while busy: ignored (default build).
- Activity LED:
  - pulse_event loads the stretch counter with N_STR.
  - led_act = (counter != 0); the counter decrements each cycle down to 0.
  - An event arriving while the counter is nonzero reloads it (retrigger), so the LED stays lit.
  - The activity path is independent of the state machine.
- All outputs are registered.

## Timing
- Reset (synchronous, while rst=1): state IDLE, remaining 0, counters 0; led_status=0, led_act=0, busy=0.
- Reset asserted mid-burst aborts the burst. The first cycle after reset deasserts is IDLE.
- Heartbeat passthrough latency: 1 cycle.
- code_valid in cycle t (IDLE):
  - busy=1 and led_status=1 from cycle t+1;
  - led_status stays high for exactly N_FLASH cycles.
- Burst of code k: exactly k high pulses of N_FLASH cycles, each followed by N_FLASH low cycles, then N_GAP low cycles.
  - busy spans 2*k*N_FLASH + N_GAP cycles.
  - IDLE (heartbeat visible, busy=0) starts on the cycle after the last GAP cycle.
- pulse_event in cycle t: led_act=1 from t+1 to t+N_STR inclusive. A retrigger at t+j extends the on-time to t+j+N_STR.
- code_valid and pulse_event in the same cycle: both are honoured.
- Counters never wrap: they load and count down to 0 only.

## Configuration
- LED_STATUS_REPEAT_EN defined:
  - The latched code is sticky. At the end of GAP, if the latched code != 0, the block re-enters ON with remaining = latched code instead of going to IDLE.
  - code_valid is accepted in any state:
    - code == 0 clears the latched code, so the current burst completes, then the block goes to IDLE;
    - a nonzero code replaces the latched code for the next burst. The current `remaining` is untouched.
- Macro undefined: one-shot burst as described above. code_valid is ignored while busy.

## Test plan
Use P_CLK_FREQ_HZ=10000, P_FLASH_MS=2, P_GAP_MS=5, P_STRETCH_MS=1, giving N_FLASH=20, N_GAP=50, N_STR=10.
- Reset, then toggle heartbeat every 100 cycles -> led_status follows it 1 cycle late; busy=0; led_act=0.
- code=3 with code_valid at cycle 0 -> led_status high at cycles 1–20, 41–60 and 81–100; low through cycle 170; busy=1 for cycles 1–170; heartbeat resumes at cycle 171.
- code=5 strobe at cycle 30 of a code=3 burst (default build) -> ignored; exactly 3 flashes.
- pulse_event at cycles 0 and 6 -> led_act high for cycles 1–16, low at cycle 17.
- rst asserted at cycle 50 of a code=4 burst -> all outputs 0 next cycle; state IDLE after release.
- LED_STATUS_REPEAT_EN, code=2 -> 2-flash burst repeats every 130 cycles; code_valid with code=0 mid-burst -> current burst completes, then IDLE.
